cmd_cfg: RTL

//  Capture-side command processor of the logic analyzer: device-end responder for the
//  16-bit host command protocol carried over UART. Decodes read/write/dump commands,

---
 rtl/cmd_cfg_if.sv | 13 +
 rtl/cmd_cfg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg_if.sv
// Command/response handshake between the UART side and the command processor.
// slave = command processor, master = UART receiver/transmitter side.
interface cmd_cfg_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (output cmd, cmd_rdy, resp_sent, input clr_cmd_rdy, resp, send_resp);
  modport slave  (input cmd, cmd_rdy, resp_sent, output clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/cmd_cfg.sv
// Logic-analyzer command processor: decodes host read/write/dump commands,
// owns the config register file and streams channel dumps from trace RAM.
module cmd_cfg #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  cmd_cfg_if.slave        bus,
  input  logic            set_capt_done,
  input  logic [LOG2-1:0] trace_end,
  output logic [LOG2-1:0] ram_addr,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  output logic [7:0]      trig_cfg,
  output logic [7:0]      ch1_trg_cfg,
  output logic [7:0]      ch2_trg_cfg,
  output logic [7:0]      ch3_trg_cfg,
  output logic [7:0]      ch4_trg_cfg,
  output logic [7:0]      ch5_trg_cfg,
  output logic [3:0]      decimator,
  output logic [7:0]      VIH,
  output logic [7:0]      VIL,
  output logic [7:0]      matchH,
  output logic [7:0]      matchL,
  output logic [7:0]      maskH,
  output logic [7:0]      maskL,
  output logic [15:0]     baud_cnt,
  output logic [LOG2-1:0] trig_pos
);

  localparam int         CW      = $clog2(ENTRIES + 1);
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

  typedef enum logic [2:0] {IDLE, WAIT_SENT, DUMP_RD, DUMP_SEND, DUMP_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      dump_ch;
  logic [5:0]      tc;
  logic [4:0][7:0] ch_trg;

  logic [1:0]  op;
  logic [5:0]  addr;
  logic [7:0]  wdata;
  logic [2:0]  chan;
  logic        addr_ok, chan_ok;
  logic [7:0]  rd_val, dump_data;
  logic [15:0] tp_ext;

  assign op      = bus.cmd[15:14];
  assign addr    = bus.cmd[13:8];
  assign wdata   = bus.cmd[7:0];
  assign chan    = bus.cmd[10:8];
  assign addr_ok = (addr <= 6'h10);
  assign chan_ok = (chan >= 3'd1) && (chan <= 3'd5);
  assign tp_ext  = 16'(trig_pos);

  // Consume strobe is combinational so the receiver sees it in the same cycle.
  assign bus.clr_cmd_rdy = (state == IDLE) && bus.cmd_rdy;

  assign trig_cfg    = {2'b00, tc};
  assign ch1_trg_cfg = ch_trg[0];
  assign ch2_trg_cfg = ch_trg[1];
  assign ch3_trg_cfg = ch_trg[2];
  assign ch4_trg_cfg = ch_trg[3];
  assign ch5_trg_cfg = ch_trg[4];

  always_comb begin
    rd_val = NEG_ACK;
    case (addr)
      6'h00: rd_val = {2'b00, tc};
      6'h01: rd_val = ch_trg[0];
      6'h02: rd_val = ch_trg[1];
      6'h03: rd_val = ch_trg[2];
      6'h04: rd_val = ch_trg[3];
      6'h05: rd_val = ch_trg[4];
      6'h06: rd_val = {4'h0, decimator};
      6'h07: rd_val = VIH;
      6'h08: rd_val = VIL;
      6'h09: rd_val = matchH;
      6'h0A: rd_val = matchL;
      6'h0B: rd_val = maskH;
      6'h0C: rd_val = maskL;
      6'h0D: rd_val = baud_cnt[15:8];
      6'h0E: rd_val = baud_cnt[7:0];
      6'h0F: rd_val = tp_ext[15:8];
      6'h10: rd_val = tp_ext[7:0];
      default: rd_val = NEG_ACK;
    endcase
  end

  always_comb begin
    dump_data = 8'h00;
    case (dump_ch)
      3'd1: dump_data = rdataCH1;
      3'd2: dump_data = rdataCH2;
      3'd3: dump_data = rdataCH3;
      3'd4: dump_data = rdataCH4;
      3'd5: dump_data = rdataCH5;
      default: dump_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dump_ch       <= '0;
      ram_addr      <= '0;
      bus.resp      <= '0;
      bus.send_resp <= 1'b0;
      tc            <= 6'h03;
      ch_trg        <= {5{8'h01}};
      decimator     <= '0;
      VIH           <= 8'hAA;
      VIL           <= 8'h55;
      matchH        <= '0;
      matchL        <= '0;
      maskH         <= '0;
      maskL         <= '0;
      baud_cnt      <= 16'h006C;
      trig_pos      <= LOG2'(1);
    end else begin
      bus.send_resp <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_rdy) begin
          state <= WAIT_SENT;
          bus.send_resp <= 1'b1;
          case (op)
            2'b00: bus.resp <= addr_ok ? rd_val : NEG_ACK;
            2'b01: begin
              bus.resp <= addr_ok ? POS_ACK : NEG_ACK;
              case (addr)
                6'h00: tc        <= wdata[5:0];
                6'h01: ch_trg[0] <= wdata;
                6'h02: ch_trg[1] <= wdata;
                6'h03: ch_trg[2] <= wdata;
                6'h04: ch_trg[3] <= wdata;
                6'h05: ch_trg[4] <= wdata;
                6'h06: decimator <= wdata[3:0];
                6'h07: VIH       <= wdata;
                6'h08: VIL       <= wdata;
                6'h09: matchH    <= wdata;
                6'h0A: matchL    <= wdata;
                6'h0B: maskH     <= wdata;
                6'h0C: maskL     <= wdata;
                6'h0D: baud_cnt[15:8] <= wdata;
                6'h0E: baud_cnt[7:0]  <= wdata;
                6'h0F: trig_pos  <= LOG2'({wdata, trig_pos[7:0]});
                6'h10: trig_pos  <= {trig_pos[LOG2-1:8], wdata};
                default: ;
              endcase
            end
            2'b10: if (chan_ok) begin
              // Dump answers with data bytes only, no ACK up front.
              state         <= DUMP_RD;
              bus.send_resp <= 1'b0;
              dump_ch       <= chan;
              ram_addr      <= trace_end;
              cnt           <= '0;
            end else begin
              bus.resp <= NEG_ACK;
            end
            default: bus.resp <= NEG_ACK;
          endcase
        end
        WAIT_SENT: if (bus.resp_sent) state <= IDLE;
        DUMP_RD:   state <= DUMP_SEND;
        DUMP_SEND: begin
          bus.resp      <= dump_data;
          bus.send_resp <= 1'b1;
          state         <= DUMP_WAIT;
        end
        DUMP_WAIT: if (bus.resp_sent) begin
          cnt      <= cnt + 1'b1;
          ram_addr <= (ram_addr == LOG2'(ENTRIES - 1)) ? '0 : ram_addr + 1'b1;
          state    <= (cnt == CW'(ENTRIES - 1)) ? IDLE : DUMP_RD;
        end
        default: state <= IDLE;
      endcase
      // Capture-done has priority over a same-cycle host write of bit 5.
      if (set_capt_done) tc[5] <= 1'b1;
    end
  end

endmodule
